bridge_tx: RTL and testbench

Serializes bus read responses into the host-facing ASCII protocol. Each read response (16-bit word) becomes a 7-byte message `M` + four uppercase hex digits + CR + LF, handed byte-by-byte to the UART transmitter. Sits directly downstream of the register bus that `bridge_rx` drives, closing the host read loop: `R1234\r\n` in, `M<data>\r\n` out. Write acknowledgements produce no output.

---
 rtl/bridge_tx.sv | 105 ++++++++++
 tb/tb_bridge_tx.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bridge_tx.sv
// bridge_tx: turns 16-bit bus read responses into 7-byte ASCII messages
// ("M" + four uppercase hex digits + CR + LF), handed one byte at a time
// to a UART transmitter over a valid/ready handshake. Write acks are ignored.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   data_i   read-response data from the bus
//   rw_i     0 = read response (transmit), 1 = write ack (ignore)
//   valid_i  single-cycle response strobe
//   ready_o  high while idle and able to capture a response
//   data_o   ASCII byte to the UART transmitter
//   valid_o  data_o is valid
//   ready_i  UART transmitter accepts data_o this cycle
module bridge_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_i,
  input  logic        rw_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned BYTE_W = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(6);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WORD_W-1:0]   word_q, word_d;

  // Nibble to uppercase ASCII hex digit.
  function automatic logic [BYTE_W-1:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) hex_char = BYTE_W'(8'h30) + BYTE_W'(n);
    else           hex_char = BYTE_W'(8'h37) + BYTE_W'(n);
  endfunction

  // State, byte index and captured word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

  // Next-state and outputs; outputs decode directly from the registers above.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    data_o  = '0;

    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i && !rw_i) begin
          word_d  = data_i;
          idx_d   = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        valid_o = 1'b1;
        case (idx_q)
          3'd0:    data_o = 8'h4D;
          3'd1:    data_o = hex_char(word_q[15:12]);
          3'd2:    data_o = hex_char(word_q[11:8]);
          3'd3:    data_o = hex_char(word_q[7:4]);
          3'd4:    data_o = hex_char(word_q[3:0]);
          3'd5:    data_o = 8'h0D;
          3'd6:    data_o = 8'h0A;
          default: data_o = '0;
        endcase
        if (ready_i) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bridge_tx.sv
module tb_bridge_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_i;
  logic        rw_i;
  logic        valid_i;
  logic        ready_o;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;

  always #5 clk = ~clk;

  bridge_tx dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .rw_i    (rw_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];
  int          rem = 0;
  bit          armed = 0;
  bit          bp_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] hexc(input int n);
    if (n < 10) return 8'(48 + n);
    return 8'(65 + n - 10);
  endfunction

  // Expected message for a captured read: 'M', four hex digits MSB first, CR, LF.
  task automatic push_msg(input logic [15:0] d);
    exp_q.push_back(8'h4D);
    for (int i = 3; i >= 0; i--) exp_q.push_back(hexc(int'((d >> (4 * i)) & 16'hF)));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Reference model: sampled mid-cycle, predicts what happens at the next rising edge.
  // rem = bytes of the current message still to be transferred.
  always @(negedge clk) begin
    if (armed) begin
      check("ready_o", 32'(ready_o), 32'(rem == 0));
      check("valid_o", 32'(valid_o), 32'(rem != 0));
      if (rem == 0) check("idle_data_o", 32'(data_o), 32'h0);
    end
    if (rst) begin
      rem = 0;
      exp_q.delete();
      armed = 1;
    end else if (armed) begin
      if (rem == 0) begin
        if (valid_i && !rw_i) begin
          push_msg(data_i);
          rem = 7;
        end
      end else if (ready_i) begin
        rem--;
      end
    end
  end

  // Monitor: pops expected bytes on every transfer and checks stability under stall.
  logic [7:0] held;
  bit         stalled = 0;
  always @(negedge clk) begin
    if (rst || !armed) begin
      stalled = 0;
    end else begin
      if (stalled && valid_o) check("stable_data_o", 32'(data_o), 32'(held));
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_byte: got %0h expected none at %0t", data_o, $time);
        end else begin
          check("byte", 32'(data_o), 32'(exp_q.pop_front()));
        end
      end
      stalled = valid_o && !ready_i;
      held    = data_o;
    end
  end

  // UART-side acceptance: always ready, or random back-pressure.
  always @(posedge clk) begin
    #1 ready_i = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic pulse(input logic [15:0] d, input logic rw);
    @(posedge clk);
    #1;
    data_i  = d;
    rw_i    = rw;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    data_i  = 16'($urandom);
    rw_i    = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (ready_o === 1'b1) done = 1;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: got ready_o=%b expected 1 within 300 cycles", ready_o);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic rw);
    wait_idle();
    pulse(d, rw);
  endtask

  initial begin
    rst     = 1'b1;
    valid_i = 1'b0;
    rw_i    = 1'b0;
    data_i  = '0;
    ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);

    send(16'hBABE, 1'b0);
    send(16'h09AF, 1'b0);
    send(16'h0000, 1'b0);
    send(16'hFFFF, 1'b0);
    send(16'h1234, 1'b1);
    repeat (5) @(posedge clk);

    // Read arriving while busy is dropped.
    send(16'hDEAD, 1'b0);
    @(posedge clk);
    pulse(16'h5678, 1'b0);

    bp_mode = 1;
    send(16'hCAFE, 1'b0);
    wait_idle();
    bp_mode = 0;

    // Abort after the third byte transfers, then a clean message.
    send(16'hF00D, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    send(16'h1234, 1'b0);

    for (int k = 0; k < 60; k++) begin
      bp_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) pulse(16'($urandom), 1'b0);
      else send(16'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    bp_mode = 0;
    wait_idle();
    repeat (5) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
